// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory-port arbiter.
//   state_e      : arbiter FSM states
//   CTRL_*       : memory_controller Ctrl encodings (2'b10 is illegal and is
//                  passed through untouched; the controller treats it as single)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] CTRL_SINGLE = 2'b00;
  localparam logic [1:0] CTRL_HORIZ  = 2'b01;
  localparam logic [1:0] CTRL_VERT   = 2'b11;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker, reusable by any shared unit.
// The search starts at ptr+1 (mod N) and wraps, so the requester named by ptr
// (the previous winner) has the lowest priority.
// Ports:
//   req         in  N      request vector
//   ptr         in  IDX_W  index of the previous winner
//   grant       out N      one-hot grant (all zero when no request)
//   grant_idx   out IDX_W  binary index of the winner (0 when none)
//   grant_valid out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // cand_idx[k] is the requester examined at search position k,
  // i.e. (ptr + 1 + k) mod N. One extra bit holds the sum before the wrap.
  logic [IDX_W-1:0] cand_idx [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr} + (IDX_W + 1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IDX_W + 1)'(N)) ?
                            IDX_W'(sum - (IDX_W + 1)'(N)) : sum[IDX_W-1:0];
    end
  endgenerate

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Walk from the far end so the nearest candidate is assigned last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[cand_idx[i]]) begin
        grant_idx   = cand_idx[i];
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule : rr_arbiter

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory_controller port among N_REQ requesters with round-robin
// arbitration, one transaction at a time. Sequences the controller's
// ENABLE/HANDSHAKE protocol and returns READ data with a done or error pulse.
// All outputs are registered.
// Ports:
//   CLK, RESET                clock (rising) / asynchronous active-low reset
//   REQ[N]                    request levels, held until DONE/ERR
//   REQ_CTRL/REQ_INDEX[2N]    per-requester Ctrl / IndexCtrl slices
//   REQ_ADDR[32N]             per-requester {row, col} address slices
//   GNT[N]                    one-hot grant, from grant until end of release
//   DONE[N], ERR[N]           one-cycle completion / timeout pulses
//   RDATA[48]                 last successfully read data
//   BUSY                      FSM not idle
//   MC_ENABLE/CTRL/INDEXCTRL/ADDRESS  towards the controller
//   MC_HANDSHAKE, MC_READ     from the controller
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT        = 32,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [2*N_REQ-1:0]    REQ_CTRL,
  input  logic [2*N_REQ-1:0]    REQ_INDEX,
  input  logic [32*N_REQ-1:0]   REQ_ADDR,
  output logic [N_REQ-1:0]      GNT,
  output logic [N_REQ-1:0]      DONE,
  output logic [N_REQ-1:0]      ERR,
  output logic [47:0]           RDATA,
  output logic                  BUSY,
  output logic                  MC_ENABLE,
  output logic [1:0]            MC_CTRL,
  output logic [1:0]            MC_INDEXCTRL,
  output logic [31:0]           MC_ADDRESS,
  input  logic                  MC_HANDSHAKE,
  input  logic [47:0]           MC_READ
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);

  // ---------------------------------------------------------------------------
  // Unpack the flat per-requester buses
  // ---------------------------------------------------------------------------
  logic [1:0]  req_ctrl_arr  [N_REQ];
  logic [1:0]  req_index_arr [N_REQ];
  logic [31:0] req_addr_arr  [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign req_ctrl_arr[gi]  = REQ_CTRL[2*gi +: 2];
      assign req_index_arr[gi] = REQ_INDEX[2*gi +: 2];
      assign req_addr_arr[gi]  = REQ_ADDR[32*gi +: 32];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [REL_W-1:0]   rel_cnt_q, rel_cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic [47:0]        rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               mc_enable_q, mc_enable_d;
  logic [1:0]         mc_ctrl_q, mc_ctrl_d;
  logic [1:0]         mc_indexctrl_q, mc_indexctrl_d;
  logic [31:0]        mc_address_q, mc_address_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req         (REQ),
    .ptr         (ptr_q),
    .grant       (arb_gnt),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gidx_d         = gidx_q;
    tmo_cnt_d      = tmo_cnt_q;
    rel_cnt_d      = rel_cnt_q;
    gnt_d          = gnt_q;
    done_d         = '0;
    err_d          = '0;
    rdata_d        = rdata_q;
    mc_enable_d    = mc_enable_q;
    mc_ctrl_d      = mc_ctrl_q;
    mc_indexctrl_d = mc_indexctrl_q;
    mc_address_d   = mc_address_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          // Command fields are latched here and stay frozen for the whole
          // transaction, whatever the requester does with its inputs.
          gnt_d          = arb_gnt;
          gidx_d         = arb_idx;
          mc_ctrl_d      = req_ctrl_arr[arb_idx];
          mc_indexctrl_d = req_index_arr[arb_idx];
          mc_address_d   = req_addr_arr[arb_idx];
          mc_enable_d    = 1'b1;
          tmo_cnt_d      = '0;
          state_d        = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // HANDSHAKE may still be high from the previous transaction while the
        // controller is only now seeing ENABLE, so it is not looked at here.
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        state_d   = ST_WAIT;
      end

      ST_WAIT: begin
        if (MC_HANDSHAKE) begin
          // Handshake takes priority over a timeout on the same cycle.
          rdata_d         = MC_READ;
          done_d[gidx_q]  = 1'b1;
          mc_enable_d     = 1'b0;
          rel_cnt_d       = '0;
          state_d         = ST_RELEASE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d[gidx_q]   = 1'b1;
          mc_enable_d     = 1'b0;
          rel_cnt_d       = '0;
          state_d         = ST_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end

      ST_RELEASE: begin
        // ENABLE stays low so the controller can return to its idle state and
        // drop HANDSHAKE before anyone is granted again.
        if (rel_cnt_q == REL_LAST) begin
          gnt_d   = '0;
          ptr_d   = gidx_q;
          state_d = ST_IDLE;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= ST_IDLE;
      ptr_q          <= PTR_RST;
      gidx_q         <= '0;
      tmo_cnt_q      <= '0;
      rel_cnt_q      <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      err_q          <= '0;
      rdata_q        <= '0;
      busy_q         <= 1'b0;
      mc_enable_q    <= 1'b0;
      mc_ctrl_q      <= '0;
      mc_indexctrl_q <= '0;
      mc_address_q   <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gidx_q         <= gidx_d;
      tmo_cnt_q      <= tmo_cnt_d;
      rel_cnt_q      <= rel_cnt_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      err_q          <= err_d;
      rdata_q        <= rdata_d;
      busy_q         <= busy_d;
      mc_enable_q    <= mc_enable_d;
      mc_ctrl_q      <= mc_ctrl_d;
      mc_indexctrl_q <= mc_indexctrl_d;
      mc_address_q   <= mc_address_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign GNT          = gnt_q;
  assign DONE         = done_q;
  assign ERR          = err_q;
  assign RDATA        = rdata_q;
  assign BUSY         = busy_q;
  assign MC_ENABLE    = mc_enable_q;
  assign MC_CTRL      = mc_ctrl_q;
  assign MC_INDEXCTRL = mc_indexctrl_q;
  assign MC_ADDRESS   = mc_address_q;

endmodule : mem_port_arbiter
